// File: rtl/vfpu_normround.sv
// Normalises a pre-norm vfpu result, rounds to nearest-even and packs binary32; iterative, one shift per cycle.
// Latency 4 + shift steps (zero: 2); starts while busy_o=1 are dropped, busy_o clears the cycle after done_o.
module vfpu_normround #(
   parameter int EXP_W     = 8,
   parameter int MANT_W    = 23,
   parameter int PN_EXP_W  = 10,
   parameter int PN_MANT_W = MANT_W + 5
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        signPreNorm_i,
   input  logic signed [PN_EXP_W-1:0]  exponentPreNorm_i,
   input  logic [PN_MANT_W-1:0]        mantissaPreNorm_i,
   input  logic                        operandsReady_i,
   output logic                        busy_o,
   output logic                        done_o,
   output logic [EXP_W+MANT_W:0]       result_o,
   output logic                        overflow_o,
   output logic                        underflow_o,
   output logic                        inexact_o
);

   localparam int XW  = PN_EXP_W + 1;
   localparam int CB  = PN_MANT_W - 1;
   localparam int HB  = PN_MANT_W - 2;
   localparam logic signed [XW-1:0] EXP_ONE = XW'(1);
   localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);

   typedef enum logic [2:0] {S_IDLE, S_NORM, S_ROUND, S_POST, S_PACK} state_e;

   state_e                   state_q, state_d;
   logic                     sign_q, sign_d;
   logic signed [XW-1:0]     exp_q, exp_d;
   logic [PN_MANT_W-1:0]     mant_q, mant_d;
   logic                     inx_q, inx_d;
   logic                     busy_q, busy_d;
   logic                     done_q, done_d;
   logic [EXP_W+MANT_W:0]    res_q, res_d;
   logic                     ovf_q, ovf_d;
   logic                     unf_q, unf_d;
   logic                     inexact_q, inexact_d;

   logic [PN_MANT_W-1:0]     mant_shr;
   logic                     round_inc;
   logic [EXP_W-1:0]         exp_field;

   always_comb begin
      state_d   = state_q;
      sign_d    = sign_q;
      exp_d     = exp_q;
      mant_d    = mant_q;
      inx_d     = inx_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      res_d     = res_q;
      ovf_d     = ovf_q;
      unf_d     = unf_q;
      inexact_d = inexact_q;
      exp_field = '0;
      // right shift keeps every discarded bit alive in the sticky position
      mant_shr  = {1'b0, mant_q[CB:2], mant_q[1] | mant_q[0]};
      round_inc = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);

      case (state_q)
         S_IDLE: begin
            busy_d = 1'b0;
            if (operandsReady_i && !busy_q) begin
               sign_d  = signPreNorm_i;
               exp_d   = {exponentPreNorm_i[PN_EXP_W-1], exponentPreNorm_i};
               mant_d  = mantissaPreNorm_i;
               inx_d   = 1'b0;
               busy_d  = 1'b1;
               state_d = S_NORM;
            end
         end
         S_NORM: begin
            if (mant_q == '0) begin
               exp_d   = '0;
               state_d = S_PACK;
            end else if (mant_q[CB] || (exp_q < EXP_ONE)) begin
               mant_d = mant_shr;
               exp_d  = exp_q + EXP_ONE;
            end else if (!mant_q[HB] && (exp_q > EXP_ONE)) begin
               mant_d = {mant_q[PN_MANT_W-2:0], 1'b0};
               exp_d  = exp_q - EXP_ONE;
            end else begin
               state_d = S_ROUND;
            end
         end
         S_ROUND: begin
            mant_d  = mant_q + {{(PN_MANT_W-4){1'b0}}, round_inc, 3'b000};
            inx_d   = |mant_q[2:0];
            state_d = S_POST;
         end
         S_POST: begin
            if (mant_q[CB]) begin
               mant_d = mant_shr;
               exp_d  = exp_q + EXP_ONE;
            end
            state_d = S_PACK;
         end
         S_PACK: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
            if (exp_q >= EXP_MAX) begin
               res_d     = {sign_q, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
               ovf_d     = 1'b1;
               unf_d     = 1'b0;
               inexact_d = 1'b1;
            end else begin
               exp_field = mant_q[HB] ? exp_q[EXP_W-1:0] : '0;
               res_d     = {sign_q, exp_field, mant_q[HB-1:3]};
               ovf_d     = 1'b0;
               unf_d     = (exp_field == '0) & inx_q;
               inexact_d = inx_q;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= S_IDLE;
         sign_q    <= 1'b0;
         exp_q     <= '0;
         mant_q    <= '0;
         inx_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         res_q     <= '0;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
         inexact_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         sign_q    <= sign_d;
         exp_q     <= exp_d;
         mant_q    <= mant_d;
         inx_q     <= inx_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         res_q     <= res_d;
         ovf_q     <= ovf_d;
         unf_q     <= unf_d;
         inexact_q <= inexact_d;
      end
   end

   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign result_o    = res_q;
   assign overflow_o  = ovf_q;
   assign underflow_o = unf_q;
   assign inexact_o   = inexact_q;

endmodule

// File: tb/tb_vfpu_normround.sv
// Directed bench for vfpu_normround: vector table with hand-computed results, flags {ovf,unf,inx} and latency,
// plus reset-abort and start-while-busy sequences.
module tb_vfpu_normround;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        sign_in;
   logic [9:0]  exp_in;
   logic [27:0] mant_in;
   logic        start;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic        ovf;
   logic        unf;
   logic        inx;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        sign;
      logic [9:0]  exp;
      logic [27:0] mant;
      logic [31:0] res;
      logic [2:0]  flg;
      int          lat;
   } vec_t;

   vec_t vecs[16];

   always #5 clk_i = ~clk_i;

   vfpu_normround dut (
      .clk_i             (clk_i),
      .rst_ni            (rst_ni),
      .signPreNorm_i     (sign_in),
      .exponentPreNorm_i (exp_in),
      .mantissaPreNorm_i (mant_in),
      .operandsReady_i   (start),
      .busy_o            (busy),
      .done_o            (done),
      .result_o          (result),
      .overflow_o        (ovf),
      .underflow_o       (unf),
      .inexact_o         (inx)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, want);
      end
   endtask

   // drives a one-cycle start and counts cycles from the accepting edge until done_o is seen
   task automatic run_vec(input logic s, input logic [9:0] e, input logic [27:0] m, output int lat);
      @(negedge clk_i);
      sign_in = s;
      exp_in  = e;
      mant_in = m;
      start   = 1'b1;
      @(negedge clk_i);
      start = 1'b0;
      lat   = 0;
      while (!done && lat < 200) begin
         @(negedge clk_i);
         lat++;
      end
   endtask

   initial begin
      int lat;
      int ndone;

      vecs[0]  = '{1'b0, 10'd127, 28'h8000000, 32'h40000000, 3'b000, 5};
      vecs[1]  = '{1'b0, 10'd130, 28'h0000008, 32'h35800000, 3'b000, 27};
      vecs[2]  = '{1'b0, 10'd127, 28'h400000C, 32'h3F800002, 3'b001, 4};
      vecs[3]  = '{1'b0, 10'd254, 28'h8000000, 32'h7F800000, 3'b101, 5};
      vecs[4]  = '{1'b1, 10'd254, 28'h8000000, 32'hFF800000, 3'b101, 5};
      vecs[5]  = '{1'b1, 10'd127, 28'h0000000, 32'h80000000, 3'b000, 2};
      vecs[6]  = '{1'b0, 10'h3FE, 28'h4000000, 32'h00100000, 3'b000, 7};
      vecs[7]  = '{1'b0, 10'd127, 28'h4000000, 32'h3F800000, 3'b000, 4};
      vecs[8]  = '{1'b0, 10'd127, 28'h4000004, 32'h3F800000, 3'b001, 4};
      vecs[9]  = '{1'b0, 10'd127, 28'h4000006, 32'h3F800001, 3'b001, 4};
      vecs[10] = '{1'b0, 10'd127, 28'h7FFFFFC, 32'h40000000, 3'b001, 4};
      vecs[11] = '{1'b0, 10'd254, 28'h7FFFFFC, 32'h7F800000, 3'b101, 4};
      vecs[12] = '{1'b0, 10'd0,   28'h4000001, 32'h00400000, 3'b011, 5};
      vecs[13] = '{1'b1, 10'd128, 28'h6000000, 32'hC0400000, 3'b000, 4};
      vecs[14] = '{1'b0, 10'd3,   28'h1000000, 32'h00800000, 3'b000, 6};
      vecs[15] = '{1'b0, 10'd2,   28'h1000000, 32'h00400000, 3'b000, 5};

      rst_ni  = 1'b0;
      start   = 1'b0;
      sign_in = 1'b0;
      exp_in  = '0;
      mant_in = '0;
      repeat (3) @(negedge clk_i);
      check("reset busy", {31'b0, busy}, 32'd0);
      check("reset done", {31'b0, done}, 32'd0);
      check("reset result", result, 32'd0);
      check("reset flags", {29'b0, ovf, unf, inx}, 32'd0);
      rst_ni = 1'b1;

      // consecutive runs also exercise back-to-back starts right after busy_o drops
      for (int i = 0; i < 16; i++) begin
         run_vec(vecs[i].sign, vecs[i].exp, vecs[i].mant, lat);
         check($sformatf("v%0d latency", i), lat, vecs[i].lat);
         check($sformatf("v%0d result", i), result, vecs[i].res);
         check($sformatf("v%0d flags", i), {29'b0, ovf, unf, inx}, {29'b0, vecs[i].flg});
      end

      // reset in the middle of a long normalisation
      @(negedge clk_i);
      sign_in = 1'b0;
      exp_in  = 10'd130;
      mant_in = 28'h0000008;
      start   = 1'b1;
      @(negedge clk_i);
      start = 1'b0;
      repeat (5) @(negedge clk_i);
      check("abort busy before reset", {31'b0, busy}, 32'd1);
      rst_ni = 1'b0;
      @(negedge clk_i);
      check("abort busy", {31'b0, busy}, 32'd0);
      check("abort result", result, 32'd0);
      check("abort flags", {29'b0, ovf, unf, inx}, 32'd0);
      rst_ni = 1'b1;
      ndone  = 0;
      repeat (40) begin
         @(negedge clk_i);
         if (done) ndone++;
      end
      check("abort done count", ndone, 0);

      // start held high throughout the operation and through the done cycle
      @(negedge clk_i);
      sign_in = 1'b0;
      exp_in  = 10'd127;
      mant_in = 28'h8000000;
      start   = 1'b1;
      @(negedge clk_i);
      sign_in = 1'b1;
      exp_in  = 10'd0;
      mant_in = 28'h0000000;
      lat     = 0;
      while (!done && lat < 200) begin
         @(negedge clk_i);
         lat++;
      end
      check("busy-start latency", lat, 5);
      check("busy-start busy at done", {31'b0, busy}, 32'd1);
      @(negedge clk_i);
      start = 1'b0;
      check("busy-start done pulse width", {31'b0, done}, 32'd0);
      check("busy-start busy after done", {31'b0, busy}, 32'd0);
      ndone = 0;
      repeat (15) begin
         @(negedge clk_i);
         if (done) ndone++;
      end
      check("busy-start extra done", ndone, 0);
      check("busy-start result held", result, 32'h40000000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
